// File: rtl/adc_conditioner.sv
// ADC conditioner: offset calibration (CAL), then offset correction and moving-average filtering (RUN).
// Define ADC_COND_DAC_EN to build the registered offset-binary DAC copy on o_dac; otherwise o_dac is tied to 0.
module adc_conditioner #(
  parameter int CAL_LOG2 = 8,
  parameter int AVG_LOG2 = 2,
  parameter int INVERT   = 1
) (
  input  logic               i_clock,
  input  logic               i_RESET,
  input  logic signed [13:0] i_data,
  input  logic               i_valid,
  input  logic               i_or,
  input  logic               i_cal_start,
  input  logic               i_or_clr,
  output logic signed [13:0] o_data,
  output logic               o_valid,
  output logic signed [13:0] o_offset,
  output logic               o_cal_busy,
  output logic               o_or_latch,
  output logic        [13:0] o_dac
);

  localparam int ACC_W = 15 + CAL_LOG2;
  localparam int AVG_N = 1 << AVG_LOG2;
  localparam int SUM_W = 15 + AVG_LOG2;

  localparam logic signed [ACC_W-1:0] ACC_POS = ACC_W'(8191);
  localparam logic signed [ACC_W-1:0] ACC_NEG = -ACC_POS;

  typedef enum logic {
    ST_CAL,
    ST_RUN
  } state_t;

  function automatic logic signed [13:0] sat14(input logic signed [15:0] v);
    if (v > 16'sd8191)       return 14'sd8191;
    else if (v < -16'sd8191) return -14'sd8191;
    else                     return v[13:0];
  endfunction

  state_t                     state_q, state_d;
  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic        [CAL_LOG2-1:0] cnt_q, cnt_d;
  logic signed [13:0]         offset_q, offset_d;
  logic signed [13:0]         c_q, c_d;
  logic                       c_vld_q, c_vld_d;
  logic signed [13:0]         hist_q [AVG_N];
  logic signed [13:0]         hist_d [AVG_N];
  logic signed [SUM_W-1:0]    sum_q, sum_d;
  logic signed [13:0]         data_q, data_d;
  logic                       valid_q, valid_d;
  logic                       or_latch_q, or_latch_d;

  logic signed [14:0]         data_ext;
  logic signed [14:0]         s;
  logic signed [ACC_W-1:0]    acc_sum;
  logic signed [ACC_W-1:0]    acc_avg;
  logic signed [13:0]         offset_sat;
  logic signed [15:0]         diff;
  logic signed [SUM_W-1:0]    sum_new;

  // 15-bit pre-processing keeps -(-8192) = +8192 representable.
  always_comb begin
    data_ext   = {i_data[13], i_data};
    s          = (INVERT != 0) ? (15'sd0 - data_ext) : data_ext;
    acc_sum    = acc_q + {{(ACC_W-15){s[14]}}, s};
    acc_avg    = acc_sum >>> CAL_LOG2;
    if (acc_avg > ACC_POS)      offset_sat = 14'sd8191;
    else if (acc_avg < ACC_NEG) offset_sat = -14'sd8191;
    else                        offset_sat = acc_avg[13:0];
    diff       = {s[14], s} - {{2{offset_q[13]}}, offset_q};
    sum_new    = sum_q + {{(SUM_W-14){c_q[13]}}, c_q}
                       - {{(SUM_W-14){hist_q[AVG_N-1][13]}}, hist_q[AVG_N-1]};
  end

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    offset_d   = offset_q;
    c_d        = c_q;
    c_vld_d    = 1'b0;
    hist_d     = hist_q;
    sum_d      = sum_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    or_latch_d = or_latch_q;

    // Set is applied after clear so a coincident set wins.
    if (i_or_clr)         or_latch_d = 1'b0;
    if (i_valid && i_or)  or_latch_d = 1'b1;

    case (state_q)
      ST_CAL: begin
        data_d = '0;
        hist_d = '{default: '0};
        sum_d  = '0;
        if (i_cal_start) begin
          acc_d = '0;
          cnt_d = '0;
        end else if (i_valid) begin
          acc_d = acc_sum;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == {CAL_LOG2{1'b1}}) begin
            offset_d = offset_sat;
            acc_d    = '0;
            cnt_d    = '0;
            state_d  = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (i_cal_start) begin
          // The sample in flight in c_q is dropped by leaving c_vld_d low.
          state_d = ST_CAL;
          data_d  = '0;
          hist_d  = '{default: '0};
          sum_d   = '0;
        end else begin
          if (i_valid) begin
            c_d     = sat14(diff);
            c_vld_d = 1'b1;
          end
          if (c_vld_q) begin
            for (int i = 1; i < AVG_N; i++) hist_d[i] = hist_q[i-1];
            hist_d[0] = c_q;
            sum_d     = sum_new;
            data_d    = 14'(sum_new >>> AVG_LOG2);
            valid_d   = 1'b1;
          end
        end
      end
      default: state_d = ST_CAL;
    endcase
  end

  always_ff @(posedge i_clock) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (i_RESET) begin
      state_q    <= ST_CAL;
      acc_q      <= '0;
      cnt_q      <= '0;
      offset_q   <= '0;
      c_q        <= '0;
      c_vld_q    <= 1'b0;
      // NOTE: the filter history is reset like any flop because the running sum depends on it.
      hist_q     <= '{default: '0};
      sum_q      <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      or_latch_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      offset_q   <= offset_d;
      c_q        <= c_d;
      c_vld_q    <= c_vld_d;
      hist_q     <= hist_d;
      sum_q      <= sum_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      or_latch_q <= or_latch_d;
    end
  end

`ifdef ADC_COND_DAC_EN
  logic [13:0] dac_q, dac_d;

  // Offset-binary: -8191 maps to 0, +8191 to 16382.
  always_comb begin
    dac_d = $unsigned(data_d) + 14'd8191;
  end

  always_ff @(posedge i_clock) begin
    if (i_RESET) dac_q <= '0;
    else         dac_q <= dac_d;
  end

  assign o_dac = dac_q;
`else
  assign o_dac = '0;
`endif

  assign o_data     = data_q;
  assign o_valid    = valid_q;
  assign o_offset   = offset_q;
  assign o_cal_busy = (state_q == ST_CAL);
  assign o_or_latch = or_latch_q;

endmodule

// File: tb/tb_adc_conditioner.sv
// Self-checking bench for adc_conditioner: directed scenarios plus randomized traffic against
// a queue-based reference model of calibration, correction and averaging.
module tb_adc_conditioner;

  localparam int CAL_LOG2 = 4;
  localparam int AVG_LOG2 = 2;
  localparam int INV      = 1;
  localparam int CAL_N    = 1 << CAL_LOG2;
  localparam int AVG_N    = 1 << AVG_LOG2;
`ifdef ADC_COND_DAC_EN
  localparam bit DAC_ON = 1'b1;
`else
  localparam bit DAC_ON = 1'b0;
`endif

  logic               i_clock = 1'b0;
  logic               i_RESET;
  logic signed [13:0] i_data;
  logic               i_valid;
  logic               i_or;
  logic               i_cal_start;
  logic               i_or_clr;
  logic signed [13:0] o_data;
  logic               o_valid;
  logic signed [13:0] o_offset;
  logic               o_cal_busy;
  logic               o_or_latch;
  logic        [13:0] o_dac;

  adc_conditioner #(
    .CAL_LOG2(CAL_LOG2),
    .AVG_LOG2(AVG_LOG2),
    .INVERT  (INV)
  ) dut (
    .i_clock    (i_clock),
    .i_RESET    (i_RESET),
    .i_data     (i_data),
    .i_valid    (i_valid),
    .i_or       (i_or),
    .i_cal_start(i_cal_start),
    .i_or_clr   (i_or_clr),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .o_offset   (o_offset),
    .o_cal_busy (o_cal_busy),
    .o_or_latch (o_or_latch),
    .o_dac      (o_dac)
  );

  always #5 i_clock = ~i_clock;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: calibration samples, averaging window and pending corrections as queues.
  bit m_run;
  int m_cal[$];
  int m_hist[$];
  int m_pend[$];
  int m_offset;
  bit m_latch;
  bit exp_valid;
  int exp_data;
  int exp_dac;

  function automatic int floor_div(input int a, input int b);
    int q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q -= 1;
    return q;
  endfunction

  function automatic int clamp(input int v);
    if (v > 8191)  return 8191;
    if (v < -8191) return -8191;
    return v;
  endfunction

  function automatic void hist_clear();
    m_hist.delete();
    for (int i = 0; i < AVG_N; i++) m_hist.push_back(0);
  endfunction

  function automatic void model_edge();
    int s;
    int sum;
    if (i_RESET) begin
      m_run = 1'b0; m_cal.delete(); m_pend.delete(); hist_clear();
      m_offset = 0; m_latch = 1'b0; exp_valid = 1'b0; exp_data = 0; exp_dac = 0;
      return;
    end
    if (i_or_clr) m_latch = 1'b0;
    if (i_valid && i_or) m_latch = 1'b1;
    s = (INV != 0) ? -int'(i_data) : int'(i_data);
    exp_valid = 1'b0;
    if (!m_run) begin
      exp_data = 0;
      m_pend.delete();
      if (i_cal_start) m_cal.delete();
      else if (i_valid) begin
        m_cal.push_back(s);
        if (m_cal.size() == CAL_N) begin
          sum = 0;
          foreach (m_cal[i]) sum += m_cal[i];
          m_offset = clamp(floor_div(sum, CAL_N));
          m_run = 1'b1;
          m_cal.delete();
          hist_clear();
        end
      end
    end else if (i_cal_start) begin
      m_run = 1'b0; exp_data = 0; m_pend.delete(); m_cal.delete(); hist_clear();
    end else begin
      if (m_pend.size() > 0) begin
        m_hist.push_front(m_pend.pop_front());
        void'(m_hist.pop_back());
        sum = 0;
        foreach (m_hist[i]) sum += m_hist[i];
        exp_data  = floor_div(sum, AVG_N);
        exp_valid = 1'b1;
      end
      if (i_valid) m_pend.push_back(clamp(s - m_offset));
    end
    exp_dac = DAC_ON ? exp_data + 8191 : 0;
  endfunction

  task automatic tick();
    @(posedge i_clock);
    model_edge();
    #1;
    check("o_valid",    int'(o_valid),    int'(exp_valid));
    check("o_data",     int'(o_data),     exp_data);
    check("o_offset",   int'(o_offset),   m_offset);
    check("o_cal_busy", int'(o_cal_busy), int'(!m_run));
    check("o_or_latch", int'(o_or_latch), int'(m_latch));
    check("o_dac",      int'(o_dac),      exp_dac);
  endtask

  task automatic samples(input int n, input int d);
    for (int k = 0; k < n; k++) begin
      i_valid = 1'b1;
      i_data  = 14'(d);
      tick();
    end
    i_valid = 1'b0;
  endtask

  task automatic do_reset();
    i_RESET = 1'b1;
    tick();
    i_RESET = 1'b0;
  endtask

  int n_cal_valid;

  initial begin
    i_RESET = 1'b1; i_data = '0; i_valid = 1'b0; i_or = 1'b0;
    i_cal_start = 1'b0; i_or_clr = 1'b0;
    tick();
    tick();
    check("rst_busy",   int'(o_cal_busy), 1);
    check("rst_offset", int'(o_offset),   0);
    check("rst_data",   int'(o_data),     0);
    i_RESET = 1'b0;

    // Calibration on -100 (inverted to +100), no output strobes while calibrating.
    n_cal_valid = 0;
    for (int k = 1; k <= CAL_N; k++) begin
      i_valid = 1'b1; i_data = -14'sd100;
      tick();
      if (o_valid) n_cal_valid++;
      if (k == CAL_N - 1) check("cal_busy_15", int'(o_cal_busy), 1);
    end
    i_valid = 1'b0;
    check("cal_busy_16", int'(o_cal_busy), 0);
    check("cal_offset",  int'(o_offset),   100);
    check("cal_no_vld",  n_cal_valid,      0);

    // Filter ramp: c = 300 - 100 = 200, averaged over four.
    for (int k = 1; k <= 10; k++) begin
      i_valid = (k <= 8); i_data = -14'sd300;
      tick();
      check("ramp_vld", int'(o_valid), int'(k >= 2 && k <= 9));
      if (k >= 2 && k <= 9) check("ramp_data", int'(o_data), (50 * (k - 1) > 200) ? 200 : 50 * (k - 1));
    end

    // Out-of-range latch: set, set+clear, clear alone.
    i_valid = 1'b1; i_or = 1'b1; i_data = -14'sd300;
    tick();
    check("or_set", int'(o_or_latch), 1);
    i_or_clr = 1'b1;
    tick();
    check("or_set_wins", int'(o_or_latch), 1);
    i_valid = 1'b0; i_or = 1'b0;
    tick();
    check("or_clr", int'(o_or_latch), 0);
    i_or_clr = 1'b0;

    // Restart mid-stream.
    samples(6, -300);
    i_valid = 1'b1; i_cal_start = 1'b1;
    tick();
    check("restart_busy", int'(o_cal_busy), 1);
    i_valid = 1'b0; i_cal_start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("restart_no_vld", int'(o_valid), 0);
    end
    samples(CAL_N, -100);
    check("recal_offset", int'(o_offset), 100);
    samples(2, -300);
    check("recal_first", int'(o_data), 50);
    check("recal_first_vld", int'(o_valid), 1);
    tick();

    // Reset after seven calibration samples discards them.
    do_reset();
    samples(7, -50);
    do_reset();
    samples(CAL_N - 1, -200);
    check("rst7_busy", int'(o_cal_busy), 1);
    samples(1, -200);
    check("rst7_done",   int'(o_cal_busy), 0);
    check("rst7_offset", int'(o_offset),   200);

    // DAC endpoints: c saturates low, then c = 0.
    samples(4, 8191);
    tick(); tick();
    check("dac_lo_data", int'(o_data), -8191);
    check("dac_lo",      int'(o_dac),  DAC_ON ? 0 : 0);
    samples(4, -200);
    tick(); tick();
    check("dac_mid_data", int'(o_data), 0);
    check("dac_mid",      int'(o_dac),  DAC_ON ? 8191 : 0);

    // Saturation: offset -100, then -8192 gives c = 8292 -> 8191.
    do_reset();
    samples(CAL_N, 100);
    check("sat_offset", int'(o_offset), -100);
    samples(4, -8192);
    tick();
    check("sat_vld4",  int'(o_valid), 1);
    check("sat_data4", int'(o_data),  8191);
    check("dac_hi",    int'(o_dac),   DAC_ON ? 16382 : 0);
    tick();

    // Randomized traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      int r;
      r = int'($urandom_range(0, 7));
      i_valid     = ($urandom_range(0, 9) < 7);
      i_data      = (r == 0) ? -14'sd8192 : (r == 1) ? 14'sd8191 : 14'($urandom_range(0, 16383));
      i_or        = ($urandom_range(0, 9) == 0);
      i_or_clr    = ($urandom_range(0, 9) == 0);
      i_cal_start = ($urandom_range(0, 99) == 0);
      i_RESET     = ($urandom_range(0, 399) == 0);
      tick();
    end
    i_valid = 1'b0; i_or = 1'b0; i_or_clr = 1'b0; i_cal_start = 1'b0; i_RESET = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
